prio_irq_encoder: RTL

//  Parametrised, registered N-channel priority encoder with request latching.

---
 rtl/prio_irq_encoder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/prio_irq_encoder.sv
// prio_irq_encoder
//   Registered N-channel priority encoder with request latching. Falling
//   edges on the active-low request lines are captured into a pending
//   register. One winning channel at a time is presented on code/valid and
//   is retired by ack. Arbitration is fixed priority (highest index wins) or
//   round-robin from a rotating pointer.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous reset, active low
//   en_n      in   arbitration enable, active low
//   req_n     in   [N] request lines, active low, falling edge raises request
//   mask      in   [N] 1 = channel not eligible for grant (pending kept)
//   ack       in   consumer accepts the current grant (only while valid=1)
//   code      out  [W] granted channel index, 0..N-1
//   valid     out  grant presented; code stable while high
//   any_pend  out  OR of all pending bits, masked ones included
//   ovf       out  one-cycle pulse: new edge on an already pending channel
module prio_irq_encoder #(
    parameter int N  = 8,
    parameter int RR = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_n,
    input  logic [N-1:0]         req_n,
    input  logic [N-1:0]         mask,
    input  logic                 ack,
    output logic [$clog2(N)-1:0] code,
    output logic                 valid,
    output logic                 any_pend,
    output logic                 ovf
);

    localparam int          W  = $clog2(N);
    localparam int unsigned NU = N;

    typedef enum logic {
        IDLE,
        GNT
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   req_s;
    logic [N-1:0]   req_d;
    logic [N-1:0]   pending;
    logic [N-1:0]   rise;
    logic [N-1:0]   clr;
    logic [N-1:0]   elig;
    logic [W-1:0]   ptr;
    logic [W-1:0]   ptr_nxt;
    logic [W-1:0]   code_nxt;
    logic [W-1:0]   win;

    assign rise     = req_s & ~req_d;
    assign elig     = en_n ? '0 : (pending & ~mask);
    assign valid    = (state == GNT);
    assign any_pend = |pending;

    // Clear only the granted bit, and only when the grant is actually shown.
    assign clr = (state == GNT && ack) ? ({{(N-1){1'b0}}, 1'b1} << code) : '0;

    // Winner selection. Round-robin takes the lowest set index at or above
    // ptr, falling back to the lowest set index overall, which is the same
    // as a circular scan starting at ptr.
    always_comb begin
        logic         any_hi;
        logic         any_lo;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        win    = '0;
        any_hi = 1'b0;
        any_lo = 1'b0;
        hi     = '0;
        lo     = '0;
        if (RR == 0) begin
            for (int unsigned i = 0; i < NU; i++) begin
                if (elig[i]) win = W'(i);
            end
        end else begin
            for (int unsigned i = 0; i < NU; i++) begin
                if (elig[i]) begin
                    if (!any_lo) begin
                        lo     = W'(i);
                        any_lo = 1'b1;
                    end
                    if (!any_hi && i >= 32'(ptr)) begin
                        hi     = W'(i);
                        any_hi = 1'b1;
                    end
                end
            end
            win = any_hi ? hi : lo;
        end
    end

    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (|elig) begin
                    state_nxt = GNT;
                    code_nxt  = win;
                end
            end
            GNT: begin
                if (ack) begin
                    state_nxt = IDLE;
                    if (RR != 0) ptr_nxt = (code == W'(N - 1)) ? '0 : code + 1'b1;
                end else if (en_n) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            code    <= '0;
            ptr     <= '0;
            req_s   <= '0;
            req_d   <= '0;
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nxt;
            code    <= code_nxt;
            ptr     <= ptr_nxt;
            req_s   <= ~req_n;
            req_d   <= req_s;
            // Set wins over clear on the same bit.
            pending <= (pending & ~clr) | rise;
            ovf     <= |(rise & pending & ~clr);
        end
    end

endmodule
